// File: rtl/dcache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_mem_ctrl
//
// Memory-side sequencer for the data cache. Takes the dcache's miss and
// writeback requests one at a time and runs each over a narrow, beat-based
// memory port:
//   - writeback: one write address phase, NBEATS write beats, one write
//     acknowledge. The dirty line is sliced low beat first.
//   - miss: one read address phase, then read beats are collected into a
//     line buffer, then the full line is offered to the dcache as a refill.
// A pending writeback always wins over a miss in the same cycle, so a
// victim reaches memory before the line that replaces it is fetched.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   miss_req_*                 miss request from dcache (valid/ready, addr, way)
//   wb_req_*                   writeback request from dcache (valid/ready, addr, line)
//   refill_*                   refill to dcache (valid/ready, addr, way, line, err)
//   mem_req_*                  memory address phase (valid/ready, write, addr)
//   mem_w*                     memory write beats (valid/ready, data, last)
//   mem_r*                     memory read beats (valid, data, last, err), no ready
//   mem_bvalid_i, mem_berr_i   memory write acknowledge
//   busy_o                     high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module dcache_mem_ctrl #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 64,
    parameter int WAY_WIDTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  miss_req_valid_i,
    output logic                  miss_req_ready_o,
    input  logic [PLEN-1:0]       miss_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]  miss_req_victim_way_i,

    input  logic                  wb_req_valid_i,
    output logic                  wb_req_ready_o,
    input  logic [PLEN-1:0]       wb_req_paddr_i,
    input  logic [LINE_WIDTH-1:0] wb_req_data_i,

    output logic                  refill_valid_o,
    input  logic                  refill_ready_i,
    output logic [PLEN-1:0]       refill_paddr_o,
    output logic [WAY_WIDTH-1:0]  refill_way_o,
    output logic [LINE_WIDTH-1:0] refill_data_o,
    output logic                  refill_err_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_write_o,
    output logic [PLEN-1:0]       mem_req_addr_o,

    output logic                  mem_wvalid_o,
    input  logic                  mem_wready_i,
    output logic [BUS_WIDTH-1:0]  mem_wdata_o,
    output logic                  mem_wlast_o,

    input  logic                  mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
    input  logic                  mem_rlast_i,
    input  logic                  mem_rerr_i,

    input  logic                  mem_bvalid_i,
    input  logic                  mem_berr_i,

    output logic                  busy_o
);

    localparam int NBEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int CW     = $clog2(NBEATS);
    localparam int OFF    = $clog2(LINE_WIDTH / 8);

    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_ADDR,
        WB_DATA,
        WB_RESP,
        RD_ADDR,
        RD_DATA,
        REFILL
    } state_e;

    state_e                            state_q, state_d;
    logic   [CW-1:0]                   beat_q;
    logic                              err_q;
    logic   [PLEN-1:0]                 addr_q;
    logic   [WAY_WIDTH-1:0]            way_q;
    // One line buffer serves both directions: it holds the victim during a
    // writeback and collects read beats during a miss. Only one transaction
    // is ever in flight, so the two uses never overlap.
    logic   [NBEATS-1:0][BUS_WIDTH-1:0] line_q;

    logic wb_acc;
    logic miss_acc;
    logic last_beat;
    logic rd_beat;
    logic wr_beat;

    // Write errors end the transaction like a normal ack and are otherwise
    // dropped; address offset bits are discarded by line alignment.
    logic unused_inputs;
    assign unused_inputs = ^{mem_berr_i, wb_req_paddr_i[OFF-1:0], miss_req_paddr_i[OFF-1:0]};

    assign wb_acc    = wb_req_valid_i && wb_req_ready_o;
    assign miss_acc  = miss_req_valid_i && miss_req_ready_o;
    assign last_beat = (beat_q == LAST_BEAT);
    assign rd_beat   = (state_q == RD_DATA) && mem_rvalid_i;
    assign wr_beat   = (state_q == WB_DATA) && mem_wready_i;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb_acc) begin
                    state_d = WB_ADDR;
                end else if (miss_acc) begin
                    state_d = RD_ADDR;
                end
            end
            WB_ADDR: begin
                if (mem_req_ready_i) begin
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                if (mem_wready_i && last_beat) begin
                    state_d = WB_RESP;
                end
            end
            WB_RESP: begin
                if (mem_bvalid_i) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (mem_req_ready_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                // The final slot ends the burst even without rlast; an early
                // rlast ends it short.
                if (mem_rvalid_i && (last_beat || mem_rlast_i)) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (refill_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        wb_req_ready_o   = 1'b0;
        miss_req_ready_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_req_write_o  = 1'b0;
        mem_wvalid_o     = 1'b0;
        mem_wlast_o      = 1'b0;
        refill_valid_o   = 1'b0;
        busy_o           = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Readies are gated by reset so nothing is accepted while
                // the block is being held in reset.
                wb_req_ready_o   = rst_ni;
                miss_req_ready_o = rst_ni && !wb_req_valid_i;
            end
            WB_ADDR: begin
                mem_req_valid_o = 1'b1;
                mem_req_write_o = 1'b1;
            end
            WB_DATA: begin
                mem_wvalid_o = 1'b1;
                mem_wlast_o  = last_beat;
            end
            RD_ADDR: begin
                mem_req_valid_o = 1'b1;
            end
            REFILL: begin
                refill_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_req_addr_o = addr_q;
    assign mem_wdata_o    = line_q[beat_q];
    assign refill_paddr_o = addr_q;
    assign refill_way_o   = way_q;
    assign refill_data_o  = line_q;
    assign refill_err_o   = err_q;

    // -----------------------------------------------------------------------
    // Beat counter and error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (miss_acc && !wb_acc) begin
                err_q <= 1'b0;
            end
            if ((state_q == WB_ADDR || state_q == RD_ADDR) && mem_req_ready_i) begin
                beat_q <= '0;
            end else if (wr_beat || rd_beat) begin
                beat_q <= beat_q + CW'(1);
            end
            if (rd_beat) begin
                // A short burst leaves stale slots in the line, so it is
                // flagged as an error.
                err_q <= err_q | mem_rerr_i | (mem_rlast_i && !last_beat);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Address, way and line buffer (payload only, no reset needed)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wb_acc) begin
            addr_q <= {wb_req_paddr_i[PLEN-1:OFF], {OFF{1'b0}}};
            line_q <= wb_req_data_i;
        end else if (miss_acc) begin
            addr_q <= {miss_req_paddr_i[PLEN-1:OFF], {OFF{1'b0}}};
            way_q  <= miss_req_victim_way_i;
        end
        if (rd_beat) begin
            line_q[beat_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_mem_ctrl
//
// Directed bench for dcache_mem_ctrl. Each scenario pushes the memory
// requests, write beats and refill it expects onto scoreboard queues derived
// from the request itself (aligned address, line slices, beat count, error
// rules). A per-cycle monitor pops those queues on every handshake, checks
// that stalled outputs hold still, and checks the ready/busy rules.
// Literal expectations from hand calculation pin the model in each scenario.
// ---------------------------------------------------------------------------
module tb_dcache_mem_ctrl;

    localparam int PLEN = 32;
    localparam int LW   = 256;
    localparam int BW   = 64;
    localparam int WW   = 2;
    localparam int NB   = LW / BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_ni;
    logic            miss_req_valid_i, miss_req_ready_o;
    logic [PLEN-1:0] miss_req_paddr_i;
    logic [WW-1:0]   miss_req_victim_way_i;
    logic            wb_req_valid_i, wb_req_ready_o;
    logic [PLEN-1:0] wb_req_paddr_i;
    logic [LW-1:0]   wb_req_data_i;
    logic            refill_valid_o, refill_ready_i;
    logic [PLEN-1:0] refill_paddr_o;
    logic [WW-1:0]   refill_way_o;
    logic [LW-1:0]   refill_data_o;
    logic            refill_err_o;
    logic            mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
    logic [PLEN-1:0] mem_req_addr_o;
    logic            mem_wvalid_o, mem_wready_i, mem_wlast_o;
    logic [BW-1:0]   mem_wdata_o;
    logic            mem_rvalid_i, mem_rlast_i, mem_rerr_i;
    logic [BW-1:0]   mem_rdata_i;
    logic            mem_bvalid_i, mem_berr_i;
    logic            busy_o;

    dcache_mem_ctrl #(.PLEN(PLEN), .LINE_WIDTH(LW), .BUS_WIDTH(BW), .WAY_WIDTH(WW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .miss_req_valid_i(miss_req_valid_i), .miss_req_ready_o(miss_req_ready_o),
        .miss_req_paddr_i(miss_req_paddr_i), .miss_req_victim_way_i(miss_req_victim_way_i),
        .wb_req_valid_i(wb_req_valid_i), .wb_req_ready_o(wb_req_ready_o),
        .wb_req_paddr_i(wb_req_paddr_i), .wb_req_data_i(wb_req_data_i),
        .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
        .refill_paddr_o(refill_paddr_o), .refill_way_o(refill_way_o),
        .refill_data_o(refill_data_o), .refill_err_o(refill_err_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_write_o(mem_req_write_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i),
        .mem_wdata_o(mem_wdata_o), .mem_wlast_o(mem_wlast_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_rlast_i(mem_rlast_i), .mem_rerr_i(mem_rerr_i),
        .mem_bvalid_i(mem_bvalid_i), .mem_berr_i(mem_berr_i),
        .busy_o(busy_o)
    );

    typedef struct { logic write; logic [PLEN-1:0] addr; } req_t;
    typedef struct { logic [BW-1:0] data; logic last; } beat_t;
    typedef struct {
        logic [PLEN-1:0] paddr;
        logic [WW-1:0]   way;
        logic [LW-1:0]   data;
        logic [LW-1:0]   mask;
        logic            err;
    } rf_t;

    req_t  exp_req[$];
    beat_t exp_w[$];
    rf_t   exp_rf[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Previous-cycle view of each valid/ready pair, for hold checks.
    logic            pv_req = 0, pr_req = 0, h_write = 0;
    logic [PLEN-1:0] h_addr = '0;
    logic            pv_w = 0, pr_w = 0, h_wlast = 0;
    logic [BW-1:0]   h_wdata = '0;
    logic            pv_rf = 0, pr_rf = 0, h_rerr = 0;
    logic [PLEN-1:0] h_rpaddr = '0;
    logic [WW-1:0]   h_rway = '0;
    logic [LW-1:0]   h_rdata = '0;

    // Snapshots taken by the scenario tasks for the literal checks.
    logic [PLEN-1:0] snap_addr;
    logic            snap_write;
    logic [BW-1:0]   snap_wdata0;
    logic [LW-1:0]   snap_rdata;
    logic            snap_rerr;
    logic [WW-1:0]   snap_way;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        req_t  r;
        beat_t b;
        rf_t   f;
        if (!rst_ni) begin
            pv_req = 0; pv_w = 0; pv_rf = 0;
            return;
        end
        chk("wb_ready_rule", LW'(wb_req_ready_o), LW'(!busy_o));
        chk("miss_ready_rule", LW'(miss_req_ready_o), LW'(!busy_o && !wb_req_valid_i));
        if (pv_req && !pr_req)
            chk("req_hold", LW'({mem_req_valid_o, mem_req_write_o, mem_req_addr_o}),
                LW'({1'b1, h_write, h_addr}));
        if (pv_w && !pr_w)
            chk("wbeat_hold", LW'({mem_wvalid_o, mem_wlast_o, mem_wdata_o}),
                LW'({1'b1, h_wlast, h_wdata}));
        if (pv_rf && !pr_rf) begin
            chk("refill_hold_ctl", LW'({refill_valid_o, refill_err_o, refill_way_o, refill_paddr_o}),
                LW'({1'b1, h_rerr, h_rway, h_rpaddr}));
            chk("refill_hold_data", refill_data_o, h_rdata);
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (exp_req.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL mem_req unexpected: got write=%0b addr=%0h", mem_req_write_o, mem_req_addr_o);
            end else begin
                r = exp_req.pop_front();
                chk("mem_req", LW'({mem_req_write_o, mem_req_addr_o}), LW'({r.write, r.addr}));
            end
        end
        if (mem_wvalid_o && mem_wready_i) begin
            if (exp_w.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL wbeat unexpected: got data=%0h", mem_wdata_o);
            end else begin
                b = exp_w.pop_front();
                chk("wbeat", LW'({mem_wlast_o, mem_wdata_o}), LW'({b.last, b.data}));
            end
        end
        if (refill_valid_o && refill_ready_i) begin
            if (exp_rf.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL refill unexpected: got paddr=%0h", refill_paddr_o);
            end else begin
                f = exp_rf.pop_front();
                chk("refill_ctl", LW'({refill_err_o, refill_way_o, refill_paddr_o}),
                    LW'({f.err, f.way, f.paddr}));
                chk("refill_data", refill_data_o & f.mask, f.data & f.mask);
            end
        end
        pv_req = mem_req_valid_o; pr_req = mem_req_ready_i;
        h_write = mem_req_write_o; h_addr = mem_req_addr_o;
        pv_w = mem_wvalid_o; pr_w = mem_wready_i; h_wdata = mem_wdata_o; h_wlast = mem_wlast_o;
        pv_rf = refill_valid_o; pr_rf = refill_ready_i;
        h_rpaddr = refill_paddr_o; h_rway = refill_way_o; h_rdata = refill_data_o; h_rerr = refill_err_o;
    endtask

    // Inputs change at posedge+1; the monitor sees them at the negedge, i.e.
    // exactly the values the DUT samples at the following posedge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_req_valid_i = 0; miss_req_paddr_i = '0; miss_req_victim_way_i = '0;
        wb_req_valid_i = 0; wb_req_paddr_i = '0; wb_req_data_i = '0;
        refill_ready_i = 0; mem_req_ready_i = 0; mem_wready_i = 0;
        mem_rvalid_i = 0; mem_rdata_i = '0; mem_rlast_i = 0; mem_rerr_i = 0;
        mem_bvalid_i = 0; mem_berr_i = 0;
    endtask

    task automatic run_wb(input logic [PLEN-1:0] pa, input logic [LW-1:0] line,
                          input int req_stall, input logic [7:0] wgap, input int b_stall,
                          input logic berr);
        req_t  r;
        beat_t b;
        int    i, g;
        r.write = 1'b1;
        r.addr  = {pa[PLEN-1:5], 5'b0};
        exp_req.push_back(r);
        for (int k = 0; k < NB; k++) begin
            b.data = line[k*BW +: BW];
            b.last = (k == NB-1);
            exp_w.push_back(b);
        end
        wb_req_valid_i = 1; wb_req_paddr_i = pa; wb_req_data_i = line;
        tick();
        wb_req_valid_i = 0;
        snap_addr = mem_req_addr_o; snap_write = mem_req_write_o;
        repeat (req_stall) tick();
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
        snap_wdata0 = mem_wdata_o;
        i = 0; g = 0;
        while (i < NB && g < 40) begin
            mem_wready_i = !wgap[g % 8];
            tick();
            if (mem_wready_i) i++;
            g++;
        end
        mem_wready_i = 0;
        if (i < NB) begin
            n_chk++; n_fail++;
            $display("FAIL wb_beats timeout: got %0d beats expected %0d", i, NB);
        end
        // Stray read beats while waiting for the ack must be ignored.
        repeat (b_stall) begin
            mem_rvalid_i = 1; mem_rlast_i = 1; mem_rerr_i = 1; mem_rdata_i = '1;
            tick();
        end
        mem_rvalid_i = 0; mem_rlast_i = 0; mem_rerr_i = 0; mem_rdata_i = '0;
        chk("wb_busy_before_b", LW'(busy_o), LW'(1));
        mem_bvalid_i = 1; mem_berr_i = berr;
        tick();
        mem_bvalid_i = 0; mem_berr_i = 0;
        chk("wb_busy_after_b", LW'(busy_o), LW'(0));
    endtask

    // rlast_at: beat index carrying rlast (NB or more = never driven).
    // rerr_at: beat index carrying rerr (-1 = none).
    task automatic run_miss(input logic [PLEN-1:0] pa, input logic [WW-1:0] way,
                            input logic [LW-1:0] line, input int rlast_at, input int rerr_at,
                            input int req_stall, input logic [7:0] rgap, input int rf_stall);
        req_t r;
        rf_t  f;
        int   nb, i, g;
        nb = (rlast_at < NB) ? rlast_at + 1 : NB;
        r.write = 1'b0;
        r.addr  = {pa[PLEN-1:5], 5'b0};
        exp_req.push_back(r);
        f.paddr = r.addr;
        f.way   = way;
        f.data  = line;
        f.mask  = '0;
        for (int k = 0; k < nb; k++) f.mask[k*BW +: BW] = '1;
        f.err   = (rerr_at >= 0 && rerr_at < nb) || (rlast_at < NB-1);
        exp_rf.push_back(f);

        miss_req_valid_i = 1; miss_req_paddr_i = pa; miss_req_victim_way_i = way;
        tick();
        miss_req_valid_i = 0;
        snap_addr = mem_req_addr_o; snap_write = mem_req_write_o;
        repeat (req_stall) tick();
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
        i = 0; g = 0;
        while (i < nb && g < 40) begin
            if (rgap[g % 8]) begin
                // Gap cycle: a stray write ack must be ignored.
                mem_rvalid_i = 0; mem_bvalid_i = 1; mem_berr_i = 1;
            end else begin
                mem_bvalid_i = 0; mem_berr_i = 0;
                mem_rvalid_i = 1;
                mem_rdata_i  = line[i*BW +: BW];
                mem_rlast_i  = (i == rlast_at);
                mem_rerr_i   = (i == rerr_at);
            end
            tick();
            if (mem_rvalid_i) begin
                i++;
                if (i < nb) chk("refill_early", LW'(refill_valid_o), LW'(0));
            end
            g++;
        end
        mem_rvalid_i = 0; mem_rlast_i = 0; mem_rerr_i = 0; mem_rdata_i = '0;
        mem_bvalid_i = 0; mem_berr_i = 0;
        if (i < nb) begin
            n_chk++; n_fail++;
            $display("FAIL rd_beats timeout: got %0d beats expected %0d", i, nb);
        end
        chk("refill_rise", LW'(refill_valid_o), LW'(1));
        snap_rdata = refill_data_o; snap_rerr = refill_err_o; snap_way = refill_way_o;
        repeat (rf_stall) tick();
        refill_ready_i = 1;
        tick();
        refill_ready_i = 0;
        chk("refill_done_idle", LW'(busy_o), LW'(0));
    endtask

    logic [LW-1:0] line_a, line_w, line_b, line_c;

    initial begin
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_w = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line_b = {64'h0123_4567_89AB_CDEF, 64'h5555_0000_5555_0000,
                  64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0};
        line_c = {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
                  64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888};

        // Reset state
        idle_inputs();
        rst_ni = 0;
        tick(); tick();
        chk("reset_outputs", LW'({busy_o, mem_req_valid_o, mem_wvalid_o, refill_valid_o,
                                  wb_req_ready_o, miss_req_ready_o}), LW'(0));
        rst_ni = 1;
        #1;
        chk("post_reset_ready", LW'({wb_req_ready_o, miss_req_ready_o}), LW'(2'b11));

        // Miss with zero-wait memory
        run_miss(32'h8000_1234, 2'd2, line_a, 3, -1, 0, 8'h00, 0);
        chk("miss_addr", LW'({snap_write, snap_addr}), LW'({1'b0, 32'h8000_1220}));
        chk("miss_line", snap_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("miss_way_err", LW'({snap_way, snap_rerr}), LW'({2'd2, 1'b0}));

        // Writeback with zero-wait memory
        run_wb(32'h8000_0040, line_w, 0, 8'h00, 0, 1'b0);
        chk("wb_addr", LW'({snap_write, snap_addr}), LW'({1'b1, 32'h8000_0040}));
        chk("wb_first_beat", LW'(snap_wdata0), LW'(64'hAAAA_AAAA_AAAA_AAAA));

        // Simultaneous writeback and miss: writeback first, miss waits
        miss_req_valid_i = 1; miss_req_paddr_i = 32'h9000_0008; miss_req_victim_way_i = 2'd1;
        wb_req_valid_i = 1; #1;
        chk("simul_miss_blocked", LW'({wb_req_ready_o, miss_req_ready_o}), LW'(2'b10));
        run_wb(32'h8000_011C, line_b, 0, 8'h00, 1, 1'b1);
        chk("simul_wb_addr", LW'(snap_addr), LW'(32'h8000_0100));
        chk("simul_miss_ready", LW'(miss_req_ready_o), LW'(1));
        run_miss(32'h9000_0008, 2'd1, line_c, 3, -1, 0, 8'h00, 0);
        chk("simul_miss_addr", LW'(snap_addr), LW'(32'h9000_0000));

        // Backpressure on every handshake
        run_wb(32'h8000_2000, line_c, 3, 8'b0110_1101, 2, 1'b0);
        run_miss(32'h8000_3010, 2'd3, line_b, 4, -1, 3, 8'b0100_1010, 5);
        chk("bp_refill_no_rlast", LW'({snap_rerr, snap_way}), LW'({1'b0, 2'd3}));
        chk("bp_refill_line", snap_rdata, line_b);

        // Errors: rerr on beat 1, then early rlast on beat 2
        run_miss(32'h8000_4000, 2'd0, line_w, 3, 1, 0, 8'h00, 0);
        chk("rerr_beat1", LW'(snap_rerr), LW'(1));
        run_miss(32'h8000_5000, 2'd1, line_a, 2, -1, 0, 8'h00, 1);
        chk("early_rlast_err", LW'(snap_rerr), LW'(1));
        chk("early_rlast_slots", LW'(snap_rdata[191:0]),
            LW'({64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));

        // Reset in the middle of a read burst
        exp_req.push_back('{write: 1'b0, addr: 32'h8000_6000});
        miss_req_valid_i = 1; miss_req_paddr_i = 32'h8000_6000; miss_req_victim_way_i = 2'd2;
        tick();
        miss_req_valid_i = 0; mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid_i = 1; mem_rdata_i = line_c[k*BW +: BW]; mem_rerr_i = 1;
            tick();
        end
        idle_inputs();
        rst_ni = 0;
        tick();
        chk("midreset_outputs", LW'({busy_o, mem_req_valid_o, mem_wvalid_o, refill_valid_o}), LW'(0));
        exp_req.delete(); exp_w.delete(); exp_rf.delete();
        rst_ni = 1;
        tick();
        run_miss(32'h8000_7040, 2'd2, line_c, 3, -1, 0, 8'h00, 0);
        chk("after_reset_miss", LW'({snap_rerr, snap_way}), LW'({1'b0, 2'd2}));
        chk("after_reset_line", snap_rdata, line_c);

        tick(); tick();
        chk("req_q_empty", LW'(exp_req.size()), LW'(0));
        chk("wbeat_q_empty", LW'(exp_w.size()), LW'(0));
        chk("refill_q_empty", LW'(exp_rf.size()), LW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Memory-side sequencer for the data cache. Owns the cache's miss request, refill and writeback handshakes and serialises them onto one narrow beat-based memory port.
- Collects read beats into a full line for refill, and splits dirty victim lines into write beats.
- Sits between the dcache and the core's memory/bus bridge. Writebacks have priority over misses so that memory ordering is preserved.

Parameters:
- PLEN, 32, physical address width.
- LINE_WIDTH, 256, cache line width in bits.
- BUS_WIDTH, 64, memory data beat width. LINE_WIDTH/BUS_WIDTH = NBEATS, which is a power of two and at least 2.
- WAY_WIDTH, 2, victim/refill way index width.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset. One clock; reset is synchronous and active-low.
- miss_req_valid_i in 1, miss_req_ready_o out 1: miss request handshake from dcache.
- miss_req_paddr_i in PLEN: miss address.
- miss_req_victim_way_i in WAY_WIDTH: way to refill.
- wb_req_valid_i in 1, wb_req_ready_o out 1: writeback handshake.
- wb_req_paddr_i in PLEN, wb_req_data_i in LINE_WIDTH: dirty victim line.
- refill_valid_o out 1, refill_ready_i in 1: refill handshake to dcache.
- refill_paddr_o out PLEN, refill_way_o out WAY_WIDTH, refill_data_o out LINE_WIDTH, refill_err_o out 1: refill payload.
- mem_req_valid_o out 1, mem_req_ready_i in 1: memory address phase.
- mem_req_write_o out 1, mem_req_addr_o out PLEN: memory address phase.
- mem_wvalid_o out 1, mem_wready_i in 1, mem_wdata_o out BUS_WIDTH, mem_wlast_o out 1: write beats.
- mem_rvalid_i in 1, mem_rdata_i in BUS_WIDTH, mem_rlast_i in 1, mem_rerr_i in 1: read beats. Always accepted; no ready.
- mem_bvalid_i in 1, mem_berr_i in 1: write acknowledge.
- busy_o out 1: high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, REFILL.
- Reset: state=IDLE, beat counter=0, err=0. All valid/ready outputs are 0; busy_o=0.
- Ready outputs:
  - wb_req_ready_o = (state==IDLE).
  - miss_req_ready_o = (state==IDLE) && !wb_req_valid_i.
  - A writeback always wins over a simultaneous miss; the miss waits until IDLE is reached again.
- Writeback path:
  - On wb accept: latch line-aligned address (low log2(LINE_WIDTH/8) bits cleared) and line data. Go to WB_ADDR.
  - WB_ADDR: mem_req_valid_o=1, write=1, addr=latched. On mem_req_ready_i go to WB_DATA with beat=0.
  - WB_DATA: mem_wvalid_o=1, mem_wdata_o=line[beat*BUS_WIDTH +: BUS_WIDTH], mem_wlast_o=(beat==NBEATS-1).
  - Each mem_wready_i increments beat. When the last beat is accepted, go to WB_RESP.
  - WB_RESP: wait for mem_bvalid_i, then IDLE.
  - mem_berr_i is ignored apart from ending the transaction; writeback errors are not reported.
  - Minimum writeback occupancy is 1 + NBEATS + 1 cycles with zero-wait memory.
- Miss path:
  - On miss accept: latch aligned address and victim way, clear err. Go to RD_ADDR.
  - RD_ADDR: mem_req_valid_o=1, write=0. On ready go to RD_DATA with beat=0.
  - RD_DATA: each mem_rvalid_i writes the beat to line buffer slot `beat`, increments beat, and ORs mem_rerr_i into err.
  - Transition to REFILL on the beat where beat==NBEATS-1, or earlier if mem_rlast_i arrives. Early rlast forces err=1; unfilled slots keep their stale values.
  - A beat arriving with mem_rlast_i=0 at beat NBEATS-1 is still treated as last.
- REFILL:
  - refill_valid_o=1 with the latched address, way, buffer and err. All payload is stable while valid is high.
  - On refill_ready_i go to IDLE. A new request can be accepted the cycle after.
- Stray or out-of-state inputs:
  - mem_rvalid_i outside RD_DATA and mem_bvalid_i outside WB_RESP are ignored.
  - Handshake inputs are sampled only in their own state.
- Back-to-back operation: there is no bubble between REFILL→IDLE and the next accept. IDLE takes 1 cycle.
- Reset mid-transaction: at the next edge, go straight to IDLE with all outputs deasserted. Partial beats are discarded. The memory side is reset together with this block.
- Counter width is log2(NBEATS) and wraps; it is cleared on each entry to WB_DATA or RD_DATA.

Test Plan:
- Miss, zero-wait memory: miss paddr 0x8000_1234, way 2; four read beats 0x11..,0x22..,0x33..,0x44.. → mem addr 0x8000_1220, write=0. refill_valid_o rises 1 cycle after the 4th beat with data {beat3,beat2,beat1,beat0}, way 2, err 0, paddr 0x8000_1220.
- Writeback: line 0x…DDDD_CCCC_BBBB_AAAA (64-bit chunks), paddr 0x8000_0040 → addr write=1 0x8000_0040; wdata beats in order AAAA, BBBB, CCCC, DDDD; wlast only on the 4th; busy_o drops the cycle after bvalid.
- Simultaneous wb and miss valid in IDLE → wb accepted first, miss_req_ready_o=0 throughout. The miss is accepted in the first IDLE cycle after bvalid.
- Backpressure: mem_req_ready_i low 3 cycles, random mem_wready_i gaps, refill_ready_i low 5 cycles → outputs stable while stalled, no beat skipped or duplicated, refill payload unchanged until ready.
- Errors: mem_rerr_i on beat 1 → refill_err_o=1. mem_rlast_i on beat 2 → REFILL after 3 beats with err=1.
- Reset during RD_DATA after 2 beats → next cycle IDLE, all valids 0. A fresh miss then completes normally with err=0.
